register_file_mp: RTL and testbench

Parametrised, multi-read-port successor to the decode-stage register memory. Runs on a single clock and has an asynchronous active-low reset. A hardware clear sequencer zeroes every entry after reset or on request. Reads are registered, same-cycle writes are forwarded to readers, and the LEGv8 zero register (XZR) is hardwired. It sits in decode and feeds the ALU operand latches.

---
 rtl/register_file_mp_pkg.sv | 14 +
 rtl/regfile_clear_fsm.sv | 55 +++++
 rtl/register_file_mp.sv | 93 +++++++++
 tb/tb_register_file_mp.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/register_file_mp_pkg.sv
// Shared constants and types for the multi-port register file.
// Word width, address width, XZR index and sequencer state encoding.
package register_file_mp_pkg;

  localparam int WORD   = 64;
  localparam int REG_AW = 5;
  localparam int XZR    = 31;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } rf_state_e;

endpackage

// File: rtl/regfile_clear_fsm.sv
// Clear sequencer: sweeps every entry to zero, then enters RUN.
// Ports: clk, rst_n, clear_req in; ready, sweep_we, clear_ptr out.
module regfile_clear_fsm
  import register_file_mp_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear_req,
  output logic          ready,
  output logic          sweep_we,
  output logic [AW-1:0] clear_ptr
);

  rf_state_e     state, state_nx;
  logic [AW-1:0] ptr_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_CLEAR;
      clear_ptr <= '0;
    end else begin
      state     <= state_nx;
      clear_ptr <= ptr_nx;
    end
  end

  always_comb begin
    state_nx = state;
    ptr_nx   = clear_ptr;
    unique case (state)
      ST_CLEAR: begin
        // pointer wraps to 0 on the last entry
        ptr_nx = clear_ptr + 1'b1;
        if (clear_ptr == AW'(DEPTH - 1))
          state_nx = ST_RUN;
      end
      ST_RUN: begin
        if (clear_req) begin
          state_nx = ST_CLEAR;
          ptr_nx   = '0;
        end
      end
      default: state_nx = ST_CLEAR;
    endcase
  end

  always_comb begin
    ready    = (state == ST_RUN);
    sweep_we = (state == ST_CLEAR);
  end

endmodule

// File: rtl/register_file_mp.sv
// Multi-read-port register file with clear sweep, bypass and XZR.
// Ports: clk, rst_n, clear_req, ready, rd_en/addr/data/valid, wr_en/addr/data.
module register_file_mp
  import register_file_mp_pkg::*;
#(
  parameter int WIDTH      = WORD,
  parameter int DEPTH      = 32,
  parameter int AW         = $clog2(DEPTH),
  parameter int READ_PORTS = 2,
  parameter int ZERO_EN    = 1,
  parameter int ZERO_IDX   = XZR,
  parameter int BYPASS     = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clear_req,
  output logic                        ready,
  input  logic [READ_PORTS-1:0]       rd_en,
  input  logic [READ_PORTS*AW-1:0]    rd_addr,
  output logic [READ_PORTS*WIDTH-1:0] rd_data,
  output logic [READ_PORTS-1:0]       rd_valid,
  input  logic                        wr_en,
  input  logic [AW-1:0]               wr_addr,
  input  logic [WIDTH-1:0]            wr_data
);

  logic             sweep_we;
  logic [AW-1:0]    clear_ptr;
  logic             wr_zero;
  logic             wr_ok;
  logic [WIDTH-1:0] mem [DEPTH];

  regfile_clear_fsm #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_clear_fsm (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_req (clear_req),
    .ready     (ready),
    .sweep_we  (sweep_we),
    .clear_ptr (clear_ptr)
  );

  assign wr_zero = (ZERO_EN != 0) && (wr_addr == AW'(ZERO_IDX));
  assign wr_ok   = ready && wr_en && !wr_zero;

  // array has no reset; the sweep does all zeroing
  always_ff @(posedge clk) begin
    if (sweep_we)
      mem[clear_ptr] <= '0;
    else if (wr_ok)
      mem[wr_addr] <= wr_data;
  end

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_rd
    logic [AW-1:0]    addr;
    logic             zero_hit;
    logic             byp_hit;
    logic [WIDTH-1:0] rd_next;
    logic [WIDTH-1:0] data_q;
    logic             valid_q;

    assign addr     = rd_addr[p*AW +: AW];
    assign zero_hit = (ZERO_EN != 0) && (addr == AW'(ZERO_IDX));
    assign byp_hit  = (BYPASS != 0) && wr_en && (wr_addr == addr);

    // XZR wins over the write-first forward
    always_comb begin
      rd_next = mem[addr];
      unique case (1'b1)
        zero_hit:             rd_next = '0;
        byp_hit && !zero_hit: rd_next = wr_data;
        default:              ;
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= ready && rd_en[p];
        if (ready && rd_en[p])
          data_q <= rd_next;
      end
    end

    assign rd_data[p*WIDTH +: WIDTH] = data_q;
    assign rd_valid[p]               = valid_q;
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Self-checking bench for register_file_mp against a behavioural model.
// Directed plan items plus randomized traffic, checked every cycle.
module tb_register_file_mp;

  localparam int W  = 64;
  localparam int D  = 32;
  localparam int AW = 5;
  localparam int RP = 2;

  logic            clk;
  logic            rst_n;
  logic            clear_req;
  logic            ready;
  logic [RP-1:0]   rd_en;
  logic [RP*AW-1:0] rd_addr;
  logic [RP*W-1:0] rd_data;
  logic [RP-1:0]   rd_valid;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [W-1:0]    wr_data;

  int n_checks = 0;
  int n_fail   = 0;

  register_file_mp dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_req (clear_req),
    .ready     (ready),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural model: busy counts remaining clear cycles
  logic [W-1:0] m_mem [D];
  logic [W-1:0] m_data [RP];
  logic [RP-1:0] m_valid;
  int busy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy    <= D;
      m_valid <= '0;
      for (int p = 0; p < RP; p++) m_data[p] <= '0;
      for (int i = 0; i < D; i++) m_mem[i] <= '0;
    end else if (busy > 0) begin
      busy    <= busy - 1;
      m_valid <= '0;
    end else begin
      for (int p = 0; p < RP; p++) begin
        int a;
        a = int'(rd_addr[p*AW +: AW]);
        m_valid[p] <= rd_en[p];
        if (rd_en[p]) begin
          if (a == 31)
            m_data[p] <= '0;
          else if (wr_en && int'(wr_addr) == a)
            m_data[p] <= wr_data;
          else
            m_data[p] <= m_mem[a];
        end
      end
      if (wr_en && wr_addr != 5'd31)
        m_mem[wr_addr] <= wr_data;
      if (clear_req) begin
        busy <= D;
        for (int i = 0; i < D; i++) m_mem[i] <= '0;
      end
    end
  end

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    check("ready", W'(ready), W'(busy == 0));
    check("rd_valid", W'(rd_valid), W'(m_valid));
    for (int p = 0; p < RP; p++)
      check($sformatf("rd_data%0d", p), rd_data[p*W +: W], m_data[p]);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en     = 1'b0;
    rd_en     = '0;
    clear_req = 1'b0;
  endtask

  task automatic wait_ready(input string name, input bit do_wr);
    int n;
    n = 0;
    while (!ready && n < 40) begin
      if (do_wr) begin
        wr_en   = 1'b1;
        wr_addr = 5'd4;
        wr_data = 64'h1234;
      end
      rd_en   = 2'b11;
      rd_addr = {5'd4, 5'd5};
      cyc();
      n++;
    end
    idle();
    check(name, W'(n), W'(32));
  endtask

  function automatic logic [AW-1:0] pick();
    if ($urandom_range(0, 3) == 0) return 5'd31;
    return AW'($urandom_range(0, 7));
  endfunction

  initial begin
    rst_n   = 1'b0;
    idle();
    rd_addr = '0;
    wr_addr = '0;
    wr_data = '0;
    repeat (3) cyc();
    check("reset_rd_data", rd_data[W-1:0], 64'h0);
    check("reset_ready", W'(ready), 64'h0);
    rst_n = 1'b1;

    // 1: sweep length and first read
    wait_ready("ready_after_reset", 1'b0);
    rd_en = 2'b11; rd_addr = {5'd5, 5'd5};
    cyc(); idle();
    check("x5_zero", rd_data[W-1:0], 64'h0);
    check("x5_valid", W'(rd_valid), 64'h3);
    cyc();
    check("valid_drop", W'(rd_valid), 64'h0);

    // 2: write then read
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'hDEADBEEF_00000001;
    cyc(); idle();
    rd_en = 2'b01; rd_addr = {5'd0, 5'd3};
    cyc(); idle();
    check("x3_read", rd_data[W-1:0], 64'hDEADBEEF_00000001);

    // 3: same-cycle bypass on both ports
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'h55;
    rd_en = 2'b11; rd_addr = {5'd7, 5'd7};
    cyc(); idle();
    check("byp_p0", rd_data[W-1:0], 64'h55);
    check("byp_p1", rd_data[2*W-1:W], 64'h55);

    // 4: XZR ignores writes, bypass included
    wr_en = 1'b1; wr_addr = 5'd31; wr_data = 64'hFFFF;
    cyc();
    rd_en = 2'b11; rd_addr = {5'd31, 5'd31};
    cyc(); idle();
    check("xzr_p0", rd_data[W-1:0], 64'h0);
    check("xzr_p1", rd_data[2*W-1:W], 64'h0);

    // 5: clear with a simultaneous write
    wr_en = 1'b1; wr_addr = 5'd1; wr_data = 64'hA;
    cyc();
    wr_addr = 5'd2; wr_data = 64'hB; clear_req = 1'b1;
    cyc(); idle();
    check("clear_ready_low", W'(ready), 64'h0);
    wait_ready("ready_after_clear", 1'b0);
    rd_en = 2'b11; rd_addr = {5'd2, 5'd1};
    cyc(); idle();
    check("x1_cleared", rd_data[W-1:0], 64'h0);
    check("x2_cleared", rd_data[2*W-1:W], 64'h0);

    // 6: reset in the middle of a sweep
    clear_req = 1'b1;
    cyc(); idle();
    repeat (10) cyc();
    rst_n = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;
    wait_ready("ready_after_midreset", 1'b1);
    rd_en = 2'b01; rd_addr = {5'd0, 5'd4};
    cyc(); idle();
    check("x4_no_write", rd_data[W-1:0], 64'h0);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      logic [AW-1:0] wa;
      wa        = pick();
      wr_en     = 1'($urandom_range(0, 1));
      wr_addr   = wa;
      wr_data   = {$urandom(), $urandom()};
      rd_en     = RP'($urandom_range(0, 3));
      rd_addr[AW-1:0]    = ($urandom_range(0, 1) == 1) ? wa : pick();
      rd_addr[2*AW-1:AW] = ($urandom_range(0, 1) == 1) ? wa : pick();
      clear_req = ($urandom_range(0, 99) == 0);
      if (i == 1000) rst_n = 1'b0;
      if (i == 1002) rst_n = 1'b1;
      cyc();
    end
    idle();
    cyc();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
